// File: rtl/spi_slave_pkg.sv
// Register map, status bit positions and the status word layout for the SPI slave port.
// Shared by the RTL and the driver model in the bench.
package spi_slave_pkg;

  localparam logic [1:0] ADDR_TX   = 2'd0;
  localparam logic [1:0] ADDR_RX   = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_CLR  = 2'd3;

  localparam int ST_TXEMPTY = 0;
  localparam int ST_DATARDY = 1;
  localparam int ST_TXFULL  = 2;
  localparam int ST_RXOVF   = 3;
  localparam int ST_TXUNF   = 4;

  typedef struct packed {
    logic [2:0] rsvd;
    logic       tx_unf;
    logic       rx_ovf;
    logic       tx_full;
    logic       datardy;
    logic       tx_empty;
  } status_t;

endpackage

// File: rtl/spi_slave_port_fifo.sv
// Generic register-based FIFO; push/pop take effect on the clock edge, head is combinational.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
// Pointers wrap modulo DEPTH (a power of two); count carries one extra bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/spi_slave_port.sv
// Bus-mapped SPI slave (MSB first, sample mosi on sclk fall, drive miso on sclk rise).
// Latency: RX push 4 clk after the last sclk fall; miso moves 3 clk after the sclk rise.
// Backpressure: none on the link; a full RX FIFO drops the byte (rx_ovf), empty TX sends 0x00 (tx_unf).
module spi_slave_port
  import spi_slave_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       wren,
  input  logic       rden,
  input  logic [1:0] addr,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso
);

  logic [2:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [2:0] ss_sync;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr;
  logic [7:0] tx_sr;
  logic [7:0] rx_byte;
  logic       rx_push;
  logic       rx_ovf;
  logic       tx_unf;

  logic       sclk_rise, sclk_fall, ss_act, ss_fall, wrap, load;
  logic       rx_pop, tx_push, tx_pop, clr;
  logic       rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0] rx_head, tx_head, tx_byte;
  logic [$clog2(DEPTH):0] rx_count, tx_count;
  logic       unused_count;
  status_t    status;

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign ss_act    = ~ss_sync[1];
  assign ss_fall   = ss_sync[2] & ~ss_sync[1];
  assign wrap      = ss_act & sclk_fall & (bit_cnt == 3'd7);
  assign load      = ss_act & (ss_fall | wrap);

  assign rx_pop  = rden && (addr == ADDR_RX) && !rx_empty;
  assign tx_push = wren && (addr == ADDR_TX);
  assign tx_pop  = load && !tx_empty;
  assign tx_byte = tx_empty ? 8'h00 : tx_head;
  assign clr     = wren && (addr == ADDR_CLR);

  assign unused_count = ^{rx_count, tx_count};

  // Sync flops idle at the deselected level so a tied-high ss_n never looks like a fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      ss_sync   <= {ss_sync[1:0], ss_n};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      rx_byte <= '0;
      rx_push <= 1'b0;
      miso    <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      if (!ss_act) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
        miso    <= 1'b0;
      end else begin
        if (sclk_fall) begin
          rx_sr   <= {rx_sr[6:0], mosi_sync[1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_push <= 1'b1;
            rx_byte <= {rx_sr[6:0], mosi_sync[1]};
          end
        end
        // The first rise of a byte re-presents bit 7, so the shift lands bit 6 on the second rise.
        if (load) begin
          tx_sr <= tx_byte;
          miso  <= tx_byte[7];
        end else if (sclk_rise) begin
          miso  <= tx_sr[7];
          tx_sr <= {tx_sr[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ovf <= 1'b0;
      tx_unf <= 1'b0;
    end else begin
      if (rx_push && rx_full && !rx_pop) rx_ovf <= 1'b1;
      else if (clr && din[0])            rx_ovf <= 1'b0;
      if (load && tx_empty)              tx_unf <= 1'b1;
      else if (clr && din[1])            tx_unf <= 1'b0;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .data  (rx_byte),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_head),
    .count (rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .data  (din),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_head),
    .count (tx_count)
  );

  assign status = '{3'b000, tx_unf, rx_ovf, tx_full, ~rx_empty, tx_empty};

  always_comb begin
    dout = 8'h00;
    case (addr)
      ADDR_RX:   dout = rx_empty ? 8'h00 : rx_head;
      ADDR_STAT: dout = status;
      default:   dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: a bit-banged SPI master plus register driver, with
// scoreboard queues for bytes expected in RX and bytes expected on miso.
module tb_spi_slave_port;
  import spi_slave_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic [7:0] dout;
  logic       wren;
  logic       rden;
  logic [1:0] addr;
  logic       sclk;
  logic       mosi;
  logic       ss_n;
  logic       miso;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];

  spi_slave_port #(.DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .dout (dout),
    .wren (wren),
    .rden (rden),
    .addr (addr),
    .sclk (sclk),
    .mosi (mosi),
    .ss_n (ss_n),
    .miso (miso)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a;
    #1 d = dout;
  endtask

  task automatic reg_pop(output logic [7:0] d);
    @(negedge clk);
    addr = ADDR_RX; rden = 1'b1;
    #1 d = dout;
    @(negedge clk);
    rden = 1'b0;
  endtask

  task automatic ss_set(input logic v);
    @(negedge clk);
    ss_n = v;
    repeat (6) @(negedge clk);
  endtask

  // Master: mosi set with the rise, miso captured just before the fall.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit chk_lat,
                          output logic [7:0] cap);
    cap = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk);
      mosi = tx[i]; sclk = 1'b1;
      repeat (6) @(negedge clk);
      cap[i] = miso;
      sclk = 1'b0;
      if (chk_lat && i == 0) begin
        addr = ADDR_STAT;
        repeat (3) @(negedge clk);
        #1 checks++;
        if (dout[ST_DATARDY] !== 1'b0) begin
          errors++; $display("FAIL rx_latency_early: datardy %b, required 0", dout[ST_DATARDY]);
        end
        @(negedge clk);
        #1 checks++;
        if (dout[ST_DATARDY] !== 1'b1) begin
          errors++; $display("FAIL rx_latency_on_time: datardy %b, required 1", dout[ST_DATARDY]);
        end
        repeat (2) @(negedge clk);
      end else begin
        repeat (6) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL reset_status: got %h, required 01", d); end
    reg_read(ADDR_RX, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_rx_dout: got %h, required 00", d); end
    checks++;
    if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b, required 0", miso); end
  endtask

  task automatic test_basic;
    logic [7:0] d, cap, e;
    reg_write(ADDR_TX, 8'hC3); tx_q.push_back(8'hC3);
    reg_write(ADDR_TX, 8'h96);
    ss_set(1'b0);
    rx_q.push_back(8'h55);
    spi_xfer(8'h55, 8, 1'b1, cap);
    e = tx_q.pop_front();
    checks++;
    if (cap !== e) begin errors++; $display("FAIL basic_miso: got %h, required %h", cap, e); end
    ss_set(1'b1);
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL basic_status_full: got %h, required 03", d); end
    reg_pop(d);
    e = rx_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL basic_pop: got %h, required %h", d, e); end
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL basic_status_empty: got %h, required 01", d); end
  endtask

  task automatic test_tx_echo;
    logic [7:0] d, cap, e;
    reg_write(ADDR_TX, 8'hA5); tx_q.push_back(8'hA5);
    ss_set(1'b0);
    rx_q.push_back(8'h3C);
    spi_xfer(8'h3C, 8, 1'b0, cap);
    e = tx_q.pop_front();
    checks++;
    if (cap !== e) begin errors++; $display("FAIL echo_miso: got %h, required %h", cap, e); end
    ss_set(1'b1);
    reg_pop(d);
    e = rx_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL echo_pop: got %h, required %h", d, e); end
    // The wrap after the byte found TX empty, so the underflow flag is up.
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL echo_status_unf: got %h, required 11", d); end
    reg_write(ADDR_CLR, 8'h02);
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL echo_status_clr: got %h, required 01", d); end
  endtask

  task automatic test_tx_full;
    logic [7:0] d, cap, e;
    for (int i = 0; i < 4; i++) begin
      reg_write(ADDR_TX, 8'h10 + 8'(i)); tx_q.push_back(8'h10 + 8'(i));
    end
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL txfull_status: got %h, required 04", d); end
    reg_write(ADDR_TX, 8'h14);
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL txfull_ignored_status: got %h, required 04", d); end
    ss_set(1'b0);
    for (int i = 0; i < 4; i++) begin
      rx_q.push_back(8'hA0 + 8'(i));
      spi_xfer(8'hA0 + 8'(i), 8, 1'b0, cap);
      e = tx_q.pop_front();
      checks++;
      if (cap !== e) begin errors++; $display("FAIL txfull_miso%0d: got %h, required %h", i, cap, e); end
    end
    ss_set(1'b1);
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h13) begin errors++; $display("FAIL txfull_after_status: got %h, required 13", d); end
    for (int i = 0; i < 4; i++) begin
      reg_pop(d);
      e = rx_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL txfull_pop%0d: got %h, required %h", i, d, e); end
    end
    reg_write(ADDR_CLR, 8'h02);
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL txfull_final_status: got %h, required 01", d); end
  endtask

  task automatic test_overflow;
    logic [7:0] d, cap, e;
    ss_set(1'b0);
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) rx_q.push_back(8'(i));
      tx_q.push_back(8'h00);
      spi_xfer(8'(i), 8, 1'b0, cap);
      e = tx_q.pop_front();
      checks++;
      if (cap !== e) begin errors++; $display("FAIL unf_miso%0d: got %h, required %h", i, cap, e); end
    end
    ss_set(1'b1);
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h1B) begin errors++; $display("FAIL ovf_status: got %h, required 1b", d); end
    reg_write(ADDR_CLR, 8'h01);
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h13) begin errors++; $display("FAIL ovf_clear_status: got %h, required 13", d); end
    for (int i = 0; i < 4; i++) begin
      reg_pop(d);
      e = rx_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL ovf_pop%0d: got %h, required %h", i, d, e); end
    end
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL ovf_drained_status: got %h, required 11", d); end
    reg_pop(d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL empty_pop_dout: got %h, required 00", d); end
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL empty_pop_status: got %h, required 11", d); end
    reg_write(ADDR_CLR, 8'h02);
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL ovf_final_status: got %h, required 01", d); end
  endtask

  task automatic test_abort;
    logic [7:0] d, cap, e;
    ss_set(1'b0);
    spi_xfer(8'hFF, 5, 1'b0, cap);
    ss_set(1'b1);
    checks++;
    if (miso !== 1'b0) begin errors++; $display("FAIL abort_miso: got %b, required 0", miso); end
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL abort_status: got %h, required 11", d); end
    ss_set(1'b0);
    rx_q.push_back(8'h62);
    spi_xfer(8'h62, 8, 1'b0, cap);
    ss_set(1'b1);
    reg_pop(d);
    e = rx_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL abort_pop: got %h, required %h", d, e); end
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL abort_no_spurious: got %h, required 11", d); end
    reg_write(ADDR_CLR, 8'h02);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d, cap;
    reg_write(ADDR_TX, 8'h11);
    reg_write(ADDR_TX, 8'h11);
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rstmid_pre_status: got %h, required 00", d); end
    ss_set(1'b0);
    spi_xfer(8'h5A, 8, 1'b0, cap);
    spi_xfer(8'hE7, 3, 1'b0, cap);
    @(negedge clk);
    reset = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rx_q.delete();
    tx_q.delete();
    reg_read(ADDR_STAT, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL rstmid_status: got %h, required 01", d); end
    reg_pop(d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL rstmid_rx_dout: got %h, required 00", d); end
    checks++;
    if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b, required 0", miso); end
  endtask

  initial begin
    reset = 1'b0; din = 8'h00; wren = 1'b0; rden = 1'b0; addr = ADDR_TX;
    sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_tx_echo();
    test_tx_full();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
